isqrt_rr_arbiter: RTL and testbench
===================================

// Module: isqrt_rr_arbiter
//
// PURPOSE
//   Shares one pipelined isqrt instance between N_REQ formula FSMs.
//   - Round-robin grant; one request per cycle is issued to isqrt.
//   - Records the requester ID of every issued operation in a tag FIFO,
//     then steers each in-order isqrt result back to the requester that issued it.
//   - Sits between formula FSM isqrt ports and a single isqrt core.
//
// PARAMETERS
//   N_REQ   2   number of requesters, >=2
//   DEPTH   8   max in-flight operations (tag FIFO depth); must be >= isqrt latency
//
// PORTS
//   clk          in   1          clock, all logic on posedge
//   rst          in   1          synchronous reset, ACTIVE-LOW
//   req_x_vld    in   N_REQ      per-requester argument valid
//   req_x        in   N_REQ*32   per-requester argument, requester i at [32*i +: 32]
//   req_x_rdy    out  N_REQ      one-hot grant: argument of requester i accepted this cycle
//   req_y_vld    out  N_REQ      one-hot result valid, routed to the owning requester
//   req_y        out  16         result data, shared by all requesters
//   isqrt_x_vld  out  1          issue to isqrt core
//   isqrt_x      out  32         argument to isqrt core
//   isqrt_y_vld  in   1          isqrt result valid (results return in issue order)
//   isqrt_y      in   16         isqrt result
//   in_flight    out  $clog2(DEPTH+1)  number of issued, unreturned operations
//   err_unexp    out  1          sticky: result arrived with no operation outstanding
//
// BEHAVIOUR
//   State registers:
//   - rr_ptr: requester with highest priority.
//   - Tag FIFO: wr_ptr, rd_ptr, count.
//   - err_unexp.
//   Reset (rst==0 at posedge):
//   - rr_ptr=0, FIFO empty, count=0, err_unexp=0.
//   - All comb outputs are 0 while FIFO empty and no vld.
//   Grant (combinational, same cycle):
//   - can_issue = (count < DEPTH). Uses the registered count; a same-cycle pop
//     does NOT free a slot.
//   - g = first i in order rr_ptr, rr_ptr+1, ... (mod N_REQ) with req_x_vld[i].
//   - If any valid and can_issue: req_x_rdy = onehot(g), isqrt_x_vld=1, isqrt_x=req_x[g].
//   - Otherwise: req_x_rdy=0, isqrt_x_vld=0, isqrt_x=0.
//   - Requesters hold req_x/req_x_vld until their rdy bit is seen.
//   On an issue:
//   - Push g into the tag FIFO.
//   - rr_ptr <= (g+1) mod N_REQ.
//   - With no issue, rr_ptr holds.
//   Return (combinational, zero latency):
//   - If isqrt_y_vld and count>0: req_y_vld = onehot(tag_head), req_y = isqrt_y; pop the FIFO.
//   - If isqrt_y_vld and count==0: result dropped, req_y_vld=0, err_unexp <= 1 (sticky until reset).
//   - If isqrt_y_vld==0: req_y_vld=0, req_y=0.
//   Simultaneous events:
//   - Push and pop in the same cycle: count unchanged; both pointers advance.
//   - A pop at count==DEPTH does not allow a push that cycle.
//   - Pointers wrap modulo DEPTH; the FIFO never overflows or underflows.
//   - in_flight = count.
//   Reset mid-operation:
//   - All tags are discarded.
//   - The isqrt core must be reset together with this block.
//   - Any stale result arriving after reset sets err_unexp.
//   Throughput: 1 issue/cycle sustained when isqrt latency < DEPTH.
//
// TESTING
//   1) Reset: rst=0 for 2 cycles with random inputs -> in_flight=0,
//      err_unexp=0, rr_ptr=0.
//   2) Single requester: req1 x=144 -> req_x_rdy=2'b10 same cycle;
//      later req_y_vld=2'b10, req_y=12; in_flight 1 -> 0.
//   3) Contention, N_REQ=2, both vld held, x0=16, x1=81:
//      - grants alternate 0,1,0,1
//      - results routed req0=4, req1=9 in issue order
//   4) Full: stall isqrt_y_vld, hold req0 vld ->
//      - exactly DEPTH=8 grants, then rdy=0 while in_flight=8
//      - one result frees a slot; the next grant comes the following cycle, not the same one
//   5) Push+pop same cycle at in_flight=3 -> stays 3;
//      tag order preserved across pointer wrap (20+ ops).
//   6) isqrt_y_vld with in_flight=0 -> req_y_vld=0, err_unexp=1 and sticky;
//      reset mid-flight (3 outstanding) -> in_flight=0.

Source files
------------

// File: rtl/isqrt_rr_arbiter.sv
// isqrt_rr_arbiter: round-robin share of one in-order isqrt core, results steered back by a tag FIFO
module isqrt_rr_arbiter #(
  parameter int N_REQ = 2,
  parameter int DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_REQ-1:0]             req_x_vld,
  input  logic [N_REQ*32-1:0]          req_x,
  output logic [N_REQ-1:0]             req_x_rdy,
  output logic [N_REQ-1:0]             req_y_vld,
  output logic [15:0]                  req_y,
  output logic                         isqrt_x_vld,
  output logic [31:0]                  isqrt_x,
  input  logic                         isqrt_y_vld,
  input  logic [15:0]                  isqrt_y,
  output logic [$clog2(DEPTH+1)-1:0]   in_flight,
  output logic                         err_unexp
);
  localparam int IW = $clog2(N_REQ);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH+1);
  logic [IW-1:0] rr_ptr, g, idx;
  logic [IW:0]   s;
  logic          any, issue, pop;
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic [IW-1:0] tags [DEPTH];
  always_comb begin
    g = rr_ptr;
    any = 1'b0;
    s = '0;
    idx = '0;
    for (int k = N_REQ-1; k >= 0; k--) begin
      s = {1'b0, rr_ptr} + (IW+1)'(k);
      idx = s >= (IW+1)'(N_REQ) ? IW'(s - (IW+1)'(N_REQ)) : IW'(s);
      if (req_x_vld[idx]) begin
        g = idx;
        any = 1'b1;
      end
    end
  end
  assign issue       = any && (count < CW'(DEPTH));
  assign pop         = isqrt_y_vld && (count != '0);
  assign req_x_rdy   = issue ? N_REQ'(1) << g : '0;
  assign isqrt_x_vld = issue;
  assign isqrt_x     = issue ? req_x[32*g +: 32] : '0;
  assign req_y_vld   = pop ? N_REQ'(1) << tags[rd_ptr] : '0;
  assign req_y       = pop ? isqrt_y : '0;
  assign in_flight   = count;
  always_ff @(posedge clk)
    if (issue) tags[wr_ptr] <= g;
  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_ptr    <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      err_unexp <= 1'b0;
    end else begin
      if (issue) begin
        wr_ptr <= wr_ptr == PW'(DEPTH-1) ? '0 : wr_ptr + 1'b1;
        rr_ptr <= g == IW'(N_REQ-1) ? '0 : g + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr == PW'(DEPTH-1) ? '0 : rd_ptr + 1'b1;
      count <= count + CW'(issue) - CW'(pop);
      if (isqrt_y_vld && count == '0) err_unexp <= 1'b1;
    end
  end
endmodule

// File: tb/tb_isqrt_rr_arbiter.sv
// tb_isqrt_rr_arbiter: randomized and directed checks against a queue-based reference model
module tb_isqrt_rr_arbiter;
  localparam int N = 2;
  localparam int D = 8;
  logic          clk = 1'b0, rst = 1'b0;
  logic [N-1:0]  req_x_vld = '0;
  logic [N*32-1:0] req_x = '0;
  logic [N-1:0]  req_x_rdy, req_y_vld;
  logic [15:0]   req_y;
  logic          isqrt_x_vld;
  logic [31:0]   isqrt_x;
  logic          isqrt_y_vld = 1'b0;
  logic [15:0]   isqrt_y = '0;
  logic [3:0]    in_flight;
  logic          err_unexp;
  int            compared = 0, mismatched = 0;
  int            m_rr = 0, e_g;
  int            tags[$];
  logic [15:0]   pend[$];
  bit            m_err = 0;
  logic [57:0]   e_vec;
  wire  [57:0]   obs = {req_x_rdy, isqrt_x_vld, isqrt_x, req_y_vld, req_y, in_flight, err_unexp};

  isqrt_rr_arbiter #(.N_REQ(N), .DEPTH(D)) dut (
    .clk(clk), .rst(rst), .req_x_vld(req_x_vld), .req_x(req_x), .req_x_rdy(req_x_rdy),
    .req_y_vld(req_y_vld), .req_y(req_y), .isqrt_x_vld(isqrt_x_vld), .isqrt_x(isqrt_x),
    .isqrt_y_vld(isqrt_y_vld), .isqrt_y(isqrt_y), .in_flight(in_flight), .err_unexp(err_unexp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] sqrt_ref(input logic [31:0] x);
    logic [15:0] r, t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | 16'(1 << b);
      if (longint'(t) * longint'(t) <= longint'(x)) r = t;
    end
    return r;
  endfunction

  // One clock of stimulus; the model predicts this cycle's outputs, then advances.
  task automatic step(input logic [N-1:0] v, input logic [31:0] x0, input logic [31:0] x1, input logic yv);
    int g, sz;
    bit iss, pop;
    @(posedge clk); #1;
    req_x_vld = v;
    req_x = {x1, x0};
    isqrt_y_vld = yv;
    isqrt_y = pend.size() > 0 ? pend[0] : 16'($urandom);
    sz = tags.size();
    g = -1;
    for (int k = N-1; k >= 0; k--) if (((v >> ((m_rr + k) % N)) & 1) != 0) g = (m_rr + k) % N;
    iss = g >= 0 && sz < D;
    pop = yv && sz > 0;
    e_vec = {iss ? 2'(1 << g) : 2'b00, iss, iss ? (g == 1 ? x1 : x0) : 32'd0,
             pop ? 2'(1 << tags[0]) : 2'b00, pop ? isqrt_y : 16'd0, 4'(sz), m_err};
    e_g = iss ? g : -1;
    if (pop) begin
      void'(tags.pop_front());
      void'(pend.pop_front());
    end
    if (yv && sz == 0) m_err = 1;
    if (iss) begin
      tags.push_back(g);
      pend.push_back(sqrt_ref(g == 1 ? x1 : x0));
      m_rr = (g + 1) % N;
    end
    @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (n) begin
      req_x_vld = N'($urandom);
      req_x = {$urandom, $urandom};
      isqrt_y_vld = 1'($urandom);
      isqrt_y = 16'($urandom);
      @(posedge clk); #1;
    end
    @(negedge clk);
    compared++;
    if ({in_flight, err_unexp} !== 5'd0) begin
      mismatched++;
      $display("FAIL reset state: got in_flight=%0d err=%b, expected 0/0", in_flight, err_unexp);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    req_x_vld = '0;
    req_x = '0;
    isqrt_y_vld = 1'b0;
    m_rr = 0;
    m_err = 0;
    tags.delete();
    pend.delete();
  endtask

  task automatic drain();
    while (tags.size() > 0) begin
      step('0, 0, 0, 1);
      compared++;
      if (obs !== e_vec) begin
        mismatched++;
        $display("FAIL drain: got %h expected %h", obs, e_vec);
      end
    end
  endtask

  task automatic test_reset();
    do_reset(2);
    step(2'b11, 32'd100, 32'd49, 0);
    compared++;
    if (obs !== e_vec || req_x_rdy !== 2'b01) begin
      mismatched++;
      $display("FAIL reset rr_ptr: got %h expected %h (rdy 01)", obs, e_vec);
    end
    drain();
  endtask

  task automatic test_single();
    step(2'b10, 32'd0, 32'd144, 0);
    compared++;
    if (obs !== e_vec || req_x_rdy !== 2'b10) begin
      mismatched++;
      $display("FAIL single grant: got %h expected %h", obs, e_vec);
    end
    step('0, 0, 0, 0);
    compared++;
    if (obs !== e_vec || in_flight !== 4'd1) begin
      mismatched++;
      $display("FAIL single in_flight: got %0d expected 1", in_flight);
    end
    step('0, 0, 0, 1);
    compared++;
    if (obs !== e_vec || req_y_vld !== 2'b10 || req_y !== 16'd12) begin
      mismatched++;
      $display("FAIL single result: got vld=%b y=%0d expected 10/12", req_y_vld, req_y);
    end
    step('0, 0, 0, 0);
    compared++;
    if (obs !== e_vec || in_flight !== 4'd0) begin
      mismatched++;
      $display("FAIL single drained: got %0d expected 0", in_flight);
    end
  endtask

  task automatic test_contention();
    for (int k = 0; k < 4; k++) begin
      step(2'b11, 32'd16, 32'd81, 0);
      compared++;
      if (obs !== e_vec || req_x_rdy !== (k % 2 ? 2'b10 : 2'b01)) begin
        mismatched++;
        $display("FAIL contention grant %0d: got %b obs %h expected %h", k, req_x_rdy, obs, e_vec);
      end
    end
    for (int k = 0; k < 4; k++) begin
      step('0, 0, 0, 1);
      compared++;
      if (obs !== e_vec || req_y_vld !== (k % 2 ? 2'b10 : 2'b01) || req_y !== (k % 2 ? 16'd9 : 16'd4)) begin
        mismatched++;
        $display("FAIL contention result %0d: got vld=%b y=%0d", k, req_y_vld, req_y);
      end
    end
  endtask

  task automatic test_full();
    int grants = 0;
    for (int k = 0; k < 10; k++) begin
      step(2'b01, $urandom, 0, 0);
      if (req_x_rdy[0]) grants++;
      compared++;
      if (obs !== e_vec) begin
        mismatched++;
        $display("FAIL full fill %0d: got %h expected %h", k, obs, e_vec);
      end
    end
    compared++;
    if (grants != D || in_flight !== 4'd8) begin
      mismatched++;
      $display("FAIL full count: got grants=%0d in_flight=%0d expected 8/8", grants, in_flight);
    end
    step(2'b01, $urandom, 0, 1);
    compared++;
    if (obs !== e_vec || req_x_rdy !== 2'b00 || req_y_vld !== 2'b01) begin
      mismatched++;
      $display("FAIL full pop no same-cycle grant: got rdy=%b yvld=%b", req_x_rdy, req_y_vld);
    end
    step(2'b01, $urandom, 0, 0);
    compared++;
    if (obs !== e_vec || req_x_rdy !== 2'b01) begin
      mismatched++;
      $display("FAIL full next grant: got rdy=%b expected 01", req_x_rdy);
    end
    drain();
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] hv = '0;
    logic [31:0] hx [N];
    repeat (3) step(2'b01, $urandom, 0, 0);
    step(2'b01, $urandom, 0, 1);
    step('0, 0, 0, 0);
    compared++;
    if (obs !== e_vec || in_flight !== 4'd3) begin
      mismatched++;
      $display("FAIL push+pop: got in_flight=%0d expected 3", in_flight);
    end
    for (int c = 0; c < 80; c++) begin
      for (int i = 0; i < N; i++) if (!hv[i] && $urandom_range(0, 3) != 0) begin
        hv[i] = 1'b1;
        hx[i] = $urandom;
      end
      step(hv, hx[0], hx[1], pend.size() > 0 && $urandom_range(0, 2) != 0);
      if (e_g >= 0) hv[e_g] = 1'b0;
      compared++;
      if (obs !== e_vec) begin
        mismatched++;
        $display("FAIL random cycle %0d: got %h expected %h", c, obs, e_vec);
      end
    end
    drain();
  endtask

  task automatic test_unexp();
    step('0, 0, 0, 1);
    compared++;
    if (obs !== e_vec || req_y_vld !== 2'b00) begin
      mismatched++;
      $display("FAIL unexpected result routed: got %b expected 00", req_y_vld);
    end
    for (int k = 0; k < 3; k++) begin
      step('0, 0, 0, 0);
      compared++;
      if (obs !== e_vec || err_unexp !== 1'b1) begin
        mismatched++;
        $display("FAIL err sticky %0d: got %b expected 1", k, err_unexp);
      end
    end
    repeat (3) step(2'b11, $urandom, $urandom, 0);
    step('0, 0, 0, 0);
    compared++;
    if (obs !== e_vec || in_flight !== 4'd3) begin
      mismatched++;
      $display("FAIL pre-reset in_flight: got %0d expected 3", in_flight);
    end
    do_reset(1);
    step('0, 0, 0, 1);
    step('0, 0, 0, 0);
    compared++;
    if (obs !== e_vec || err_unexp !== 1'b1) begin
      mismatched++;
      $display("FAIL stale result after reset: got err=%b expected 1", err_unexp);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_full();
    test_back_to_back();
    test_unexp();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
